// File: rtl/hazard_ctrl_unit.sv
// ID-stage pipeline controller: instruction decode, ID/EX control register,
// load-use and branch-operand stalls, branch-taken flush and multiply freeze.
// exValid_o marks a real instruction in EX; a bubble has every ex* output at 0.
// The ID/EX register accepts the decoded bundle whenever pcWrite_o is 1, holds
// while mulBusy_o is 1, and takes a bubble while stall_o is 1.
module hazard_ctrl_unit #(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [6:0]        opCode_i,
   input  logic [6:0]        funct7_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic              equal_i,
   output logic              pcWrite_o,
   output logic              ifidWrite_o,
   output logic              flush_o,
   output logic              branch_o,
   output logic              stall_o,
   output logic              mulBusy_o,
   output logic              exValid_o,
   output logic              exAluSrc_o,
   output logic              exMemRead_o,
   output logic              exMemWrite_o,
   output logic              exMemToReg_o,
   output logic              exRegWrite_o,
   output logic              exIsMul_o,
   output logic [1:0]        exAluOp_o,
   output logic [REG_AW-1:0] exRd_o,
   output logic              dbgState_o
);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [6:0] F7_MUL = 7'b0000001;
   // Count value on the last EX cycle of a mul; equals 0 when MUL_LAT is 1.
   localparam logic [4:0] CNT_LAST = 5'(MUL_LAT - 1);

   typedef struct packed {
      logic              valid;
      logic              aluSrc;
      logic              memRead;
      logic              memWrite;
      logic              memToReg;
      logic              regWrite;
      logic              isMul;
      logic [1:0]        aluOp;
      logic [REG_AW-1:0] rd;
   } ctrl_t;

   typedef enum logic {
      RUN      = 1'b0,
      MUL_WAIT = 1'b1
   } state_t;

   state_t     state, stateNext;
   logic [4:0] cnt, cntNext;
   ctrl_t      dec, exReg, exNext;
   logic       useRs1, useRs2, isBranch;
   logic       freeze, loadUse, brHazard, stall, taken;

   // Decode the instruction in ID into its EX control bundle and operand use.
   always_comb begin
      dec      = '0;
      useRs1   = 1'b0;
      useRs2   = 1'b0;
      isBranch = 1'b0;
      case (opCode_i)
         OP_R: begin
            dec.valid    = 1'b1;
            dec.aluOp    = 2'b10;
            dec.regWrite = 1'b1;
            dec.isMul    = (funct7_i == F7_MUL);
            dec.rd       = rd_i;
            useRs1       = 1'b1;
            useRs2       = 1'b1;
         end
         OP_I: begin
            dec.valid    = 1'b1;
            dec.aluOp    = 2'b01;
            dec.aluSrc   = 1'b1;
            dec.regWrite = 1'b1;
            dec.rd       = rd_i;
            useRs1       = 1'b1;
         end
         OP_LD: begin
            dec.valid    = 1'b1;
            dec.aluSrc   = 1'b1;
            dec.memRead  = 1'b1;
            dec.memToReg = 1'b1;
            dec.regWrite = 1'b1;
            dec.rd       = rd_i;
            useRs1       = 1'b1;
         end
         OP_ST: begin
            dec.valid    = 1'b1;
            dec.aluSrc   = 1'b1;
            dec.memWrite = 1'b1;
            useRs1       = 1'b1;
            useRs2       = 1'b1;
         end
         OP_BR: begin
            dec.valid = 1'b1;
            dec.aluOp = 2'b01;
            useRs1    = 1'b1;
            useRs2    = 1'b1;
            isBranch  = 1'b1;
         end
         default: ;
      endcase
   end

   // Hazard detection in priority order: freeze masks stalls, stalls mask branches.
   always_comb begin
      freeze   = exReg.valid & exReg.isMul & (cnt != CNT_LAST);
      loadUse  = exReg.valid & exReg.memRead & (exReg.rd != '0) &
                 ((useRs1 & (exReg.rd == rs1_i)) | (useRs2 & (exReg.rd == rs2_i)));
      brHazard = isBranch & exReg.valid & exReg.regWrite & (exReg.rd != '0) &
                 ((exReg.rd == rs1_i) | (exReg.rd == rs2_i));
      stall    = ~freeze & (loadUse | brHazard);
      taken    = ~freeze & ~stall & isBranch & equal_i;
   end

   // Next state, freeze counter and ID/EX contents.
   always_comb begin
      stateNext = RUN;
      cntNext   = '0;
      exNext    = dec;
      if (freeze) begin
         stateNext = MUL_WAIT;
         cntNext   = cnt + 5'd1;
         exNext    = exReg;
      end else if (stall) begin
         exNext = '0;
      end
   end

   // State register, freeze counter and ID/EX register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= RUN;
         cnt   <= '0;
         exReg <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         exReg <= exNext;
      end
   end

   assign pcWrite_o    = ~rst_i & ~freeze & ~stall;
   assign ifidWrite_o  = ~rst_i & ~freeze & ~stall;
   assign branch_o     = ~rst_i & taken;
   assign flush_o      = ~rst_i & taken;
   assign stall_o      = ~rst_i & stall;
   assign mulBusy_o    = ~rst_i & freeze;

   assign exValid_o    = exReg.valid;
   assign exAluSrc_o   = exReg.aluSrc;
   assign exMemRead_o  = exReg.memRead;
   assign exMemWrite_o = exReg.memWrite;
   assign exMemToReg_o = exReg.memToReg;
   assign exRegWrite_o = exReg.regWrite;
   assign exIsMul_o    = exReg.isMul;
   assign exAluOp_o    = exReg.aluOp;
   assign exRd_o       = exReg.rd;
   assign dbgState_o   = (state == MUL_WAIT);

endmodule
